// File: rtl/fwrisc_hazard_pkg.sv
// ---------------------------------------------------------------------------
// fwrisc_hazard_pkg
//   Shared types and constants for the decode/exec hazard controller.
//   - state_t    : issue controller state (RUN issues, DRAIN waits for
//                  outstanding writes to retire after a flush)
//   - reg_addr_t : 6-bit register address (GPRs plus CSR shadow)
//   - REG_ZERO   : the hard-wired zero register, never tracked
// ---------------------------------------------------------------------------
package fwrisc_hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef logic [5:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 6'd0;

endpackage : fwrisc_hazard_pkg

// File: rtl/fwrisc_scoreboard.sv
// ---------------------------------------------------------------------------
// fwrisc_scoreboard
//   One bit per register address; a set bit means a write to that address
//   has been issued and not yet written back.
//   Ports:
//     clock, reset          : clock, synchronous active-high reset
//     set_i, set_addr_i     : mark an address pending (issue of a write)
//     clr_i, clr_addr_i     : mark an address free (writeback)
//     rs1_addr_i/rs1_busy_o : source A lookup
//     rs2_addr_i/rs2_busy_o : source B lookup
//     rd_addr_i/rd_busy_o   : destination lookup (WAW check)
//     wb_addr_i/wb_busy_o   : writeback lookup (writeback legality check)
//   All lookups read the registered vector; updates are visible next cycle.
// ---------------------------------------------------------------------------
module fwrisc_scoreboard
    import fwrisc_hazard_pkg::*;
#(
    parameter int NUM_REGS = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       set_i,
    input  logic [5:0] set_addr_i,
    input  logic       clr_i,
    input  logic [5:0] clr_addr_i,
    input  logic [5:0] rs1_addr_i,
    output logic       rs1_busy_o,
    input  logic [5:0] rs2_addr_i,
    output logic       rs2_busy_o,
    input  logic [5:0] rd_addr_i,
    output logic       rd_busy_o,
    input  logic [5:0] wb_addr_i,
    output logic       wb_busy_o
);

    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;

    // Set and clear never address the same bit in one cycle (a pending
    // destination blocks issue), so their order here does not matter.
    always_comb begin
        sb_d = sb_q;
        if (clr_i) begin
            sb_d[clr_addr_i] = 1'b0;
        end
        if (set_i) begin
            sb_d[set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign rs1_busy_o = sb_q[rs1_addr_i];
    assign rs2_busy_o = sb_q[rs2_addr_i];
    assign rd_busy_o  = sb_q[rd_addr_i];
    assign wb_busy_o  = sb_q[wb_addr_i];

endmodule : fwrisc_scoreboard

// File: rtl/fwrisc_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwrisc_hazard_ctrl
//   Issue controller sitting between decode and exec. Tracks in-flight
//   register writes, stalls decode on RAW/WAW hazards or when too many writes
//   are outstanding, and drains outstanding writes after a flush before
//   issue resumes. Only the valid/ready handshake is gated; operands pass by.
//   Ports:
//     clock, reset                  : clock, synchronous active-high reset
//     dec_valid_i                   : decode presents an instruction
//     dec_rs1_i, dec_rs1_used_i     : source A address / source A is read
//     dec_rs2_i, dec_rs2_used_i     : source B address / source B is read
//     dec_rd_i, dec_rd_wr_i         : destination address / writes rd
//     dec_ready_o                   : instruction accepted this cycle
//     exec_ready_i                  : exec can take an instruction
//     issue_valid_o                 : instruction may be issued to exec
//     wb_valid_i, wb_rd_i           : writeback of wb_rd_i completes
//     flush_req_i                   : single-cycle flush request
//     flush_done_o                  : single-cycle pulse when drain ends
//     busy_o                        : tracked writes outstanding
//     err_o                         : sticky bad-writeback flag
// ---------------------------------------------------------------------------
module fwrisc_hazard_ctrl
    import fwrisc_hazard_pkg::*;
#(
    parameter int NUM_REGS    = 64,
    parameter int MAX_PENDING = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dec_valid_i,
    input  logic [5:0] dec_rs1_i,
    input  logic       dec_rs1_used_i,
    input  logic [5:0] dec_rs2_i,
    input  logic       dec_rs2_used_i,
    input  logic [5:0] dec_rd_i,
    input  logic       dec_rd_wr_i,
    output logic       dec_ready_o,
    input  logic       exec_ready_i,
    output logic       issue_valid_o,
    input  logic       wb_valid_i,
    input  logic [5:0] wb_rd_i,
    input  logic       flush_req_i,
    output logic       flush_done_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] pendCnt_q;
    logic [CNT_W-1:0] pendCnt_d;
    logic             err_q;
    logic             err_d;
    logic             flushDone;

    logic rs1Busy;
    logic rs2Busy;
    logic rdBusy;
    logic wbBusy;

    logic hazard;
    logic tracked;
    logic atLimit;
    logic issueOk;
    logic sbSet;
    logic wbGood;
    logic wbBad;

    fwrisc_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .set_i      (sbSet),
        .set_addr_i (dec_rd_i),
        .clr_i      (wbGood),
        .clr_addr_i (wb_rd_i),
        .rs1_addr_i (dec_rs1_i),
        .rs1_busy_o (rs1Busy),
        .rs2_addr_i (dec_rs2_i),
        .rs2_busy_o (rs2Busy),
        .rd_addr_i  (dec_rd_i),
        .rd_busy_o  (rdBusy),
        .wb_addr_i  (wb_rd_i),
        .wb_busy_o  (wbBusy)
    );

    // Register zero is never tracked, so it is masked out of every check.
    // There is no writeback bypass: a bit cleared this cycle unblocks next cycle.
    assign hazard = (dec_rs1_used_i & (dec_rs1_i != REG_ZERO) & rs1Busy)
                  | (dec_rs2_used_i & (dec_rs2_i != REG_ZERO) & rs2Busy)
                  | (dec_rd_wr_i    & (dec_rd_i  != REG_ZERO) & rdBusy);

    assign tracked = dec_rd_wr_i & (dec_rd_i != REG_ZERO);
    assign atLimit = (pendCnt_q == CNT_W'(MAX_PENDING));

    // The pending limit only stalls instructions that would add an entry.
    assign issueOk = (state_q == RUN) & ~flush_req_i & ~hazard & ~(tracked & atLimit);

    assign issue_valid_o = dec_valid_i & issueOk;
    assign dec_ready_o   = issue_valid_o & exec_ready_i;

    assign sbSet  = dec_ready_o & tracked;
    assign wbGood = wb_valid_i & (wb_rd_i != REG_ZERO) & wbBusy;
    assign wbBad  = wb_valid_i & ~wbGood;

    // Simultaneous issue and retire cancel out in the counter.
    always_comb begin
        pendCnt_d = pendCnt_q;
        if (sbSet & ~wbGood) begin
            pendCnt_d = pendCnt_q + CNT_W'(1);
        end else if (wbGood & ~sbSet) begin
            pendCnt_d = pendCnt_q - CNT_W'(1);
        end
    end

    assign err_d = err_q | wbBad;

    // DRAIN exits on the registered count, so even an empty pipeline spends
    // one cycle in DRAIN; flush_done marks that exit cycle.
    always_comb begin
        state_d   = state_q;
        flushDone = 1'b0;
        case (state_q)
            RUN: begin
                if (flush_req_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pendCnt_q == '0) begin
                    state_d   = RUN;
                    flushDone = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            pendCnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pendCnt_q <= pendCnt_d;
            err_q     <= err_d;
        end
    end

    assign flush_done_o = flushDone;
    assign busy_o       = (pendCnt_q != '0);
    assign err_o        = err_q;

endmodule : fwrisc_hazard_ctrl

// File: tb/tb_fwrisc_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwrisc_hazard_ctrl
//   Directed walk through the hazard controller's main scenarios followed by
//   randomized traffic. Every cycle's outputs are compared against a reference
//   model that keeps the outstanding writes as a list of addresses.
// ---------------------------------------------------------------------------
module tb_fwrisc_hazard_ctrl;

    localparam int MAXP = 4;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [5:0] rs1;
        logic       rs1u;
        logic [5:0] rs2;
        logic       rs2u;
        logic [5:0] rd;
        logic       rdwr;
        logic       execRdy;
        logic       wbv;
        logic [5:0] wbrd;
        logic       flush;
    } stim_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       dec_valid_i;
    logic [5:0] dec_rs1_i;
    logic       dec_rs1_used_i;
    logic [5:0] dec_rs2_i;
    logic       dec_rs2_used_i;
    logic [5:0] dec_rd_i;
    logic       dec_rd_wr_i;
    logic       dec_ready_o;
    logic       exec_ready_i;
    logic       issue_valid_o;
    logic       wb_valid_i;
    logic [5:0] wb_rd_i;
    logic       flush_req_i;
    logic       flush_done_o;
    logic       busy_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding write addresses, drain flag, sticky error.
    logic [5:0] mPend[$];
    bit         mDrain;
    bit         mErr;

    fwrisc_hazard_ctrl #(
        .NUM_REGS    (64),
        .MAX_PENDING (MAXP)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .dec_valid_i    (dec_valid_i),
        .dec_rs1_i      (dec_rs1_i),
        .dec_rs1_used_i (dec_rs1_used_i),
        .dec_rs2_i      (dec_rs2_i),
        .dec_rs2_used_i (dec_rs2_used_i),
        .dec_rd_i       (dec_rd_i),
        .dec_rd_wr_i    (dec_rd_wr_i),
        .dec_ready_o    (dec_ready_o),
        .exec_ready_i   (exec_ready_i),
        .issue_valid_o  (issue_valid_o),
        .wb_valid_i     (wb_valid_i),
        .wb_rd_i        (wb_rd_i),
        .flush_req_i    (flush_req_i),
        .flush_done_o   (flush_done_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit isPending(input logic [5:0] a);
        for (int i = 0; i < mPend.size(); i++) begin
            if (mPend[i] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s.rst = 1'b0; s.valid = 1'b0;
        s.rs1 = '0; s.rs1u = 1'b0; s.rs2 = '0; s.rs2u = 1'b0;
        s.rd = '0; s.rdwr = 1'b0; s.execRdy = 1'b1;
        s.wbv = 1'b0; s.wbrd = '0; s.flush = 1'b0;
        return s;
    endfunction

    function automatic stim_t instr(input logic [5:0] rs1, input logic rs1u,
                                    input logic [5:0] rs2, input logic rs2u,
                                    input logic [5:0] rd, input logic rdwr);
        stim_t s = idleStim();
        s.valid = 1'b1;
        s.rs1 = rs1; s.rs1u = rs1u; s.rs2 = rs2; s.rs2u = rs2u;
        s.rd = rd; s.rdwr = rdwr;
        return s;
    endfunction

    function automatic stim_t withWb(input stim_t base, input logic [5:0] a);
        stim_t s = base;
        s.wbv = 1'b1;
        s.wbrd = a;
        return s;
    endfunction

    // Drives one cycle: inputs after the falling edge, outputs compared just
    // after that, model advanced on the rising edge.
    task automatic applyStimulus(input stim_t s);
        bit hz, trk, ok, expIv, expRdy, wbOk;
        @(negedge clock);
        reset          = s.rst;
        dec_valid_i    = s.valid;
        dec_rs1_i      = s.rs1;
        dec_rs1_used_i = s.rs1u;
        dec_rs2_i      = s.rs2;
        dec_rs2_used_i = s.rs2u;
        dec_rd_i       = s.rd;
        dec_rd_wr_i    = s.rdwr;
        exec_ready_i   = s.execRdy;
        wb_valid_i     = s.wbv;
        wb_rd_i        = s.wbrd;
        flush_req_i    = s.flush;

        hz  = (s.rs1u && s.rs1 != 0 && isPending(s.rs1)) ||
              (s.rs2u && s.rs2 != 0 && isPending(s.rs2)) ||
              (s.rdwr && s.rd  != 0 && isPending(s.rd));
        trk = s.rdwr && (s.rd != 0);
        ok  = !mDrain && !s.flush && !hz && !(trk && mPend.size() >= MAXP);
        expIv  = s.valid && ok;
        expRdy = expIv && s.execRdy;
        #1;
        if (!s.rst) begin
            checkOutput("issue_valid", {31'd0, issue_valid_o}, {31'd0, expIv});
            checkOutput("dec_ready",   {31'd0, dec_ready_o},   {31'd0, expRdy});
            checkOutput("busy",        {31'd0, busy_o},        {31'd0, mPend.size() != 0});
            checkOutput("err",         {31'd0, err_o},         {31'd0, mErr});
            checkOutput("flush_done",  {31'd0, flush_done_o},  {31'd0, mDrain && mPend.size() == 0});
        end

        @(posedge clock);
        if (s.rst) begin
            mPend.delete();
            mDrain = 1'b0;
            mErr   = 1'b0;
        end else begin
            wbOk = s.wbv && s.wbrd != 0 && isPending(s.wbrd);
            if (s.wbv && !wbOk) mErr = 1'b1;
            if (mDrain) mDrain = (mPend.size() != 0);
            else if (s.flush) mDrain = 1'b1;
            if (wbOk) begin
                for (int i = 0; i < mPend.size(); i++) begin
                    if (mPend[i] == s.wbrd) begin
                        mPend.delete(i);
                        break;
                    end
                end
            end
            if (expRdy && trk) mPend.push_back(s.rd);
        end
    endtask

    task automatic randomCycles(input int n, input bit allowBad);
        stim_t s;
        for (int c = 0; c < n; c++) begin
            s = idleStim();
            s.valid   = ($urandom_range(0, 9) < 7);
            s.rs1     = 6'($urandom_range(0, 7));
            s.rs1u    = 1'($urandom_range(0, 1));
            s.rs2     = 6'($urandom_range(0, 7));
            s.rs2u    = 1'($urandom_range(0, 1));
            s.rd      = 6'($urandom_range(0, 9));
            s.rdwr    = ($urandom_range(0, 3) != 0);
            s.execRdy = ($urandom_range(0, 4) != 0);
            s.flush   = ($urandom_range(0, 19) == 0);
            if (mPend.size() != 0 && $urandom_range(0, 1) == 1) begin
                s.wbv  = 1'b1;
                s.wbrd = mPend[$urandom_range(0, mPend.size() - 1)];
            end
            if (allowBad && $urandom_range(0, 29) == 0) begin
                s.wbv  = 1'b1;
                s.wbrd = 6'($urandom_range(0, 63));
            end
            s.rst = ($urandom_range(0, 149) == 0);
            applyStimulus(s);
        end
    endtask

    stim_t st;

    initial begin
        $display("[TB] starting");
        st = idleStim();
        st.rst = 1'b1;
        applyStimulus(st);
        applyStimulus(st);
        applyStimulus(idleStim());

        // RAW on x5, released one cycle after its writeback
        applyStimulus(instr(6'd0, 1'b0, 6'd0, 1'b0, 6'd5, 1'b1));
        applyStimulus(instr(6'd5, 1'b1, 6'd0, 1'b0, 6'd7, 1'b1));
        applyStimulus(withWb(instr(6'd5, 1'b1, 6'd0, 1'b0, 6'd7, 1'b1), 6'd5));
        applyStimulus(instr(6'd5, 1'b1, 6'd0, 1'b0, 6'd7, 1'b1));
        applyStimulus(withWb(idleStim(), 6'd7));

        // Pending limit: x1..x4 fill it, x6 stalls, untracked passes
        for (int r = 1; r <= 4; r++) applyStimulus(instr(6'd0, 1'b0, 6'd0, 1'b0, 6'(r), 1'b1));
        applyStimulus(instr(6'd0, 1'b0, 6'd0, 1'b0, 6'd6, 1'b1));
        applyStimulus(instr(6'd8, 1'b1, 6'd9, 1'b1, 6'd6, 1'b0));
        applyStimulus(withWb(instr(6'd0, 1'b0, 6'd0, 1'b0, 6'd6, 1'b1), 6'd1));
        applyStimulus(instr(6'd0, 1'b0, 6'd0, 1'b0, 6'd6, 1'b1));

        // Zero-register instructions while full
        applyStimulus(instr(6'd0, 1'b1, 6'd0, 1'b1, 6'd0, 1'b1));
        st = instr(6'd0, 1'b1, 6'd0, 1'b1, 6'd0, 1'b1);
        st.execRdy = 1'b0;
        applyStimulus(st);

        // Flush with two writes pending
        applyStimulus(withWb(idleStim(), 6'd2));
        applyStimulus(withWb(idleStim(), 6'd3));
        st = instr(6'd0, 1'b0, 6'd0, 1'b0, 6'd10, 1'b1);
        st.flush = 1'b1;
        applyStimulus(st);
        applyStimulus(withWb(instr(6'd0, 1'b0, 6'd0, 1'b0, 6'd10, 1'b1), 6'd4));
        applyStimulus(instr(6'd0, 1'b0, 6'd0, 1'b0, 6'd10, 1'b1));
        applyStimulus(withWb(instr(6'd0, 1'b0, 6'd0, 1'b0, 6'd10, 1'b1), 6'd6));
        applyStimulus(instr(6'd0, 1'b0, 6'd0, 1'b0, 6'd10, 1'b1));
        applyStimulus(instr(6'd0, 1'b0, 6'd0, 1'b0, 6'd10, 1'b1));
        applyStimulus(withWb(idleStim(), 6'd10));

        // Flush on an empty pipeline with a valid instruction
        st = instr(6'd1, 1'b1, 6'd0, 1'b0, 6'd11, 1'b1);
        st.flush = 1'b1;
        applyStimulus(st);
        applyStimulus(instr(6'd1, 1'b1, 6'd0, 1'b0, 6'd11, 1'b1));
        applyStimulus(instr(6'd1, 1'b1, 6'd0, 1'b0, 6'd11, 1'b1));

        // Bad writebacks set a sticky error, leaving x11 pending
        applyStimulus(withWb(idleStim(), 6'd7));
        applyStimulus(withWb(idleStim(), 6'd0));
        applyStimulus(instr(6'd11, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0));

        // Reset during a drain, then a writeback of a pre-reset write
        st = idleStim();
        st.flush = 1'b1;
        applyStimulus(st);
        applyStimulus(idleStim());
        st = idleStim();
        st.rst = 1'b1;
        applyStimulus(st);
        applyStimulus(idleStim());
        applyStimulus(withWb(idleStim(), 6'd11));
        applyStimulus(idleStim());

        st = idleStim();
        st.rst = 1'b1;
        applyStimulus(st);
        randomCycles(600, 1'b0);
        randomCycles(400, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fwrisc_hazard_ctrl
